// File: rtl/video_timing_gen.sv
// Video timing generator: fetches a frame buffer and emits aligned sync/DE/colour.
// Define VIDEO_TIMING_GEN_PATTERN_EN to add pat_sel and a colour-bar test pattern.
module video_timing_gen #(
  parameter int RES_W      = 640,
  parameter int RES_H      = 480,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int COLOR_BITS = 4,
  parameter int RD_LATENCY = 1,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0
) (
  input  logic                            pclk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [3*COLOR_BITS-1:0]         r_data,
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  input  logic                            pat_sel,
`endif
  output logic [$clog2(RES_W*RES_H)-1:0]  r_addr,
  output logic                            r_en,
  output logic [COLOR_BITS-1:0]           red,
  output logic [COLOR_BITS-1:0]           green,
  output logic [COLOR_BITS-1:0]           blue,
  output logic                            hsync,
  output logic                            vsync,
  output logic                            de,
  output logic [$clog2(RES_W)-1:0]        pixel_x,
  output logic [$clog2(RES_H)-1:0]        pixel_y,
  output logic                            frame_start,
  output logic                            line_start
);

  localparam int H_TOT = RES_W + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = RES_H + V_FP + V_SYNC + V_BP;
  localparam int XW = $clog2(RES_W);
  localparam int YW = $clog2(RES_H);
  localparam int AW = $clog2(RES_W * RES_H);
  localparam int CW = $clog2(H_TOT);
  localparam int LW = $clog2(V_TOT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic          act;
    logic          hs;
    logic          vs;
    logic          fs;
    logic          ls;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    logic          pat;
`endif
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pix_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic [AW-1:0] addr;

  int   col_i;
  int   ln_i;
  logic run;
  logic act;
  logic col_last;
  logic line_last;
  logic frm_last;
  logic px_last;

  assign col_i     = int'(col);
  assign ln_i      = int'(line);
  assign run       = state != IDLE;
  assign act       = run && col_i < RES_W && ln_i < RES_H;
  assign col_last  = col_i == H_TOT - 1;
  assign line_last = ln_i == V_TOT - 1;
  assign frm_last  = col_last && line_last;
  assign px_last   = col_i == RES_W - 1 && ln_i == RES_H - 1;

  // A stop request only takes effect at the end of a complete frame.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      col   <= '0;
      line  <= '0;
      addr  <= '0;
    end else begin
      unique case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= frm_last ? IDLE : DRAIN;
        DRAIN: begin
          if (en)            state <= RUN;
          else if (frm_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (run) begin
        if (col_last) begin
          col  <= '0;
          line <= line_last ? '0 : line + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (frm_last || (act && px_last)) addr <= '0;
        else if (act)                     addr <= addr + 1'b1;
      end
    end
  end

  pix_t fetch;

  always_comb begin
    fetch     = '0;
    fetch.act = act;
    fetch.hs  = run && col_i >= RES_W + H_FP
                    && col_i <  RES_W + H_FP + H_SYNC;
    fetch.vs  = run && ln_i >= RES_H + V_FP
                    && ln_i <  RES_H + V_FP + V_SYNC;
    fetch.fs  = run && col_i == 0 && ln_i == 0;
    fetch.ls  = run && col_i == 0;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    fetch.pat = pat_sel;
`endif
    fetch.x   = col[XW-1:0];
    fetch.y   = line[YW-1:0];
  end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  assign r_en = act && !pat_sel;
`else
  assign r_en = act;
`endif
  assign r_addr = addr;

  pix_t pipe [RD_LATENCY];
  pix_t o;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= fetch;
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign o = pipe[RD_LATENCY-1];

  logic [3*COLOR_BITS-1:0] src;

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  logic [2:0] bar;
  logic [2:0] rgb;
  assign bar = 3'((int'(o.x) * 8) / RES_W);
  // white,yellow,cyan,green,magenta,red,blue,black as {R,G,B}
  assign rgb = {~bar[1], ~bar[2], ~bar[0]};
  assign src = o.pat ? {{COLOR_BITS{rgb[2]}},
                        {COLOR_BITS{rgb[1]}},
                        {COLOR_BITS{rgb[0]}}} : r_data;
`else
  assign src = r_data;
`endif

  assign {red, green, blue} = o.act ? src : '0;
  assign de          = o.act;
  assign pixel_x     = o.act ? o.x : '0;
  assign pixel_y     = o.act ? o.y : '0;
  assign hsync       = o.hs ? HSYNC_POL : ~HSYNC_POL;
  assign vsync       = o.vs ? VSYNC_POL : ~VSYNC_POL;
  assign frame_start = o.fs;
  assign line_start  = o.ls;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: frame-position reference model, random frame buffer
// contents, directed start/stop/reset scenarios and randomized en toggling.
module tb_video_timing_gen;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int HT  = 14;
  localparam int VT  = 7;
  localparam int FR  = HT * VT;
  localparam int LAT = 2;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic        en   = 1'b0;
  logic [11:0] r_data;
  logic [4:0]  r_addr;
  logic        r_en;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync, de;
  logic [2:0]  pixel_x;
  logic [1:0]  pixel_y;
  logic        frame_start, line_start;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  logic        pat_sel = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  video_timing_gen #(
    .RES_W(W), .RES_H(H),
    .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_FP(1), .V_SYNC(1), .V_BP(1),
    .COLOR_BITS(4), .RD_LATENCY(LAT),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .pclk(pclk), .rst(rst), .en(en), .r_data(r_data),
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    .pat_sel(pat_sel),
`endif
    .r_addr(r_addr), .r_en(r_en),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .de(de),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .line_start(line_start)
  );

  always #5 pclk = ~pclk;

  // Frame buffer with two-cycle read latency; garbage when not read.
  logic [11:0] mem [32];
  logic [11:0] d1, d2;
  always @(posedge pclk) begin
    d1 <= r_en ? mem[r_addr] : 12'($urandom);
    d2 <= d1;
  end
  assign r_data = d2;

  typedef struct {
    bit act, hs, vs, fs, ls, pat;
    int x, y;
  } rec_t;

  bit   mrun = 0;
  int   mpos = 0;
  rec_t cur, q0, q1;
  int   tickn = 0;

  function automatic bit pat_now();
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    return pat_sel;
`else
    return 1'b0;
`endif
  endfunction

  // Expected fetch-stage content from position within the frame.
  function automatic rec_t frec(bit run, int pos);
    rec_t r;
    int c = pos % HT;
    int l = pos / HT;
    r.act = run && c < W && l < H;
    r.hs  = run && c >= W + 2 && c < W + 2 + 3;
    r.vs  = run && l >= H + 1 && l < H + 1 + 1;
    r.fs  = run && pos == 0;
    r.ls  = run && c == 0;
    r.pat = 1'b0;
    r.x   = c;
    r.y   = l;
    return r;
  endfunction

  function automatic logic [11:0] bar_rgb(int x);
    logic [2:0] tbl [8];
    logic [2:0] b;
    tbl = '{3'b111, 3'b110, 3'b011, 3'b010,
            3'b101, 3'b100, 3'b001, 3'b000};
    b = tbl[(x * 8) / W];
    return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    rec_t o = q1;
    logic [11:0] ec;
    chk("r_en", 32'(r_en), 32'(cur.act && !pat_now()));
    if (cur.act) chk("r_addr", 32'(r_addr), cur.y * W + cur.x);
    chk("de", 32'(de), 32'(o.act));
    chk("hsync", 32'(hsync), 32'(!o.hs));
    chk("vsync", 32'(vsync), 32'(!o.vs));
    chk("frame_start", 32'(frame_start), 32'(o.fs));
    chk("line_start", 32'(line_start), 32'(o.ls));
    chk("pixel_x", 32'(pixel_x), o.act ? o.x : 0);
    chk("pixel_y", 32'(pixel_y), o.act ? o.y : 0);
    if (!o.act)     ec = '0;
    else if (o.pat) ec = bar_rgb(o.x);
    else            ec = mem[o.y * W + o.x];
    chk("colour", 32'({red, green, blue}), 32'(ec));
  endtask

  task automatic tick();
    bit e, r;
    @(posedge pclk);
    e = en;
    r = rst;
    cur.pat = pat_now();
    q1 = q0;
    q0 = cur;
    if (r) begin
      mrun = 0;
      mpos = 0;
      q0   = frec(0, 0);
      q1   = frec(0, 0);
    end else if (!mrun) begin
      if (e) begin
        mrun = 1;
        mpos = 0;
      end
    end else if (mpos == FR - 1) begin
      mrun = e;
      mpos = 0;
    end else begin
      mpos++;
    end
    cur = frec(mrun, mpos);
    tickn++;
    #1;
    check_all();
  endtask

  int t0;
  int vcnt;
  int n;
  bit found;
  int fs_t[$];

  initial begin
    foreach (mem[i]) mem[i] = 12'($urandom);
    cur = frec(0, 0);
    q0  = cur;
    q1  = cur;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) tick();
    chk("rst_hsync", 32'(hsync), 32'(1));
    chk("rst_de", 32'(de), 32'(0));

    // Continuous run of two-plus frames from reset release.
    rst  = 1'b0;
    t0   = tickn;
    vcnt = 0;
    repeat (2 * FR + 10) begin
      tick();
      if (frame_start) fs_t.push_back(tickn - t0 - 1);
      if (!vsync && tickn - t0 - 1 >= 2 && tickn - t0 - 1 < 100) vcnt++;
    end
    chk("fs_count", fs_t.size(), 3);
    if (fs_t.size() >= 2) begin
      chk("fs_first", fs_t[0], 2);
      chk("frame_period", fs_t[1] - fs_t[0], FR);
    end
    chk("vsync_low", vcnt, 14);

    // Drop en mid-frame at line 2 col 3; the frame must complete.
    found = 0;
    for (int i = 0; i < FR + 5 && !found; i++) begin
      if (mrun && mpos == 2 * HT + 3) found = 1;
      else tick();
    end
    chk("wait_l2c3", 32'(found), 32'(1));
    en = 1'b0;
    n  = 0;
    while (mrun && n < 2 * FR) begin
      tick();
      n++;
    end
    chk("drain_len", n, FR - (2 * HT + 3));
    repeat (5) tick();
    chk("idle_r_en", 32'(r_en), 32'(0));
    chk("idle_de", 32'(de), 32'(0));

    // Restart from idle: frame_start shows LAT cycles after first RUN cycle.
    en    = 1'b1;
    n     = 0;
    found = 0;
    while (!found && n < 10) begin
      tick();
      n++;
      if (frame_start) found = 1;
    end
    chk("restart_fs", n, LAT + 1);

    // Randomized en toggling.
    repeat (500) begin
      en = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Reset mid-frame at line 3 col 5.
    en    = 1'b1;
    found = 0;
    for (int i = 0; i < 3 * FR && !found; i++) begin
      if (mrun && mpos == 3 * HT + 5) found = 1;
      else tick();
    end
    chk("wait_l3c5", 32'(found), 32'(1));
    rst = 1'b1;
    #1;
    chk("rr_r_en", 32'(r_en), 32'(0));
    chk("rr_r_addr", 32'(r_addr), 32'(0));
    chk("rr_de", 32'(de), 32'(0));
    chk("rr_colour", 32'({red, green, blue}), 32'(0));
    chk("rr_px", 32'({pixel_x, pixel_y}), 32'(0));
    chk("rr_pulses", 32'({frame_start, line_start}), 32'(0));
    chk("rr_sync", 32'({hsync, vsync}), 32'(2'b11));
    repeat (2) tick();
    rst = 1'b0;
    repeat (FR + 20) tick();

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    pat_sel = 1'b1;
    repeat (FR + 5) begin
      tick();
      if (de && pixel_x == 3'd0)
        chk("pat_white", 32'({red, green, blue}), 32'(12'hfff));
      if (de && pixel_x == 3'd7)
        chk("pat_black", 32'({red, green, blue}), 32'(0));
    end
    pat_sel = 1'b0;
    repeat (20) tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter RES_W, default 640, active pixels per line.
REQ-002 SHALL have parameter RES_H, default 480, active lines per frame.
REQ-003 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter COLOR_BITS, default 4, bits per colour channel.
REQ-006 SHALL have parameter RD_LATENCY, default 1, range 1..8, frame-buffer read latency in pclk cycles.
REQ-007 SHALL have parameters HSYNC_POL/VSYNC_POL, defaults 0/0; 0 = sync pulse active-low, 1 = active-high.
REQ-008 pclk  input  1  pixel clock; only clock in the block.
REQ-009 rst  input  1  asynchronous, active-high reset.
REQ-010 en  input  1  run request; level-sensitive.
REQ-011 r_data  input  3*COLOR_BITS  buffer read data {R,G,B}, valid RD_LATENCY cycles after r_en.
REQ-012 r_addr  output  $clog2(RES_W*RES_H)  buffer read address.
REQ-013 r_en  output  1  buffer read strobe.
REQ-014 red/green/blue  output  COLOR_BITS each  video colour.
REQ-015 hsync, vsync  output  1 each  sync outputs, polarity per REQ-007.
REQ-016 de  output  1  active-video data enable, aligned with colour outputs.
REQ-017 pixel_x, pixel_y  output  $clog2(RES_W), $clog2(RES_H)  coordinates of the pixel on the colour outputs.
REQ-018 frame_start, line_start  output  1 each  single-cycle pulses, aligned with colour outputs.

Function
REQ-019 Fetch-stage counters: col 0..H_TOT-1 (H_TOT=RES_W+H_FP+H_SYNC+H_BP), line 0..V_TOT-1 (V_TOT=RES_H+V_FP+V_SYNC+V_BP); col wraps to 0 after H_TOT-1, incrementing line, which wraps to 0 after V_TOT-1.
REQ-020 Region order per axis: active (0..RES-1), front porch, sync, back porch.
REQ-021 FSM states IDLE, RUN, DRAIN: IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->RUN when en=1; DRAIN->IDLE at the cycle col=H_TOT-1 and line=V_TOT-1.
REQ-022 In IDLE: col=line=0 held, r_en=0, sync outputs inactive, de=0; first RUN cycle processes col=0,line=0.
REQ-023 Fetch stage: r_en=1 iff state≠IDLE and col<RES_W and line<RES_H; r_addr=line*RES_W+col, generated as a running counter reset to 0 at col=0,line=0.
REQ-024 All outputs (colour, de, hsync, vsync, pixel_x/y, pulses) SHALL be delayed exactly RD_LATENCY cycles from the fetch stage via a shift pipeline, so colour equals r_data of the matching r_addr.
REQ-025 red/green/blue = r_data fields when de=1, else 0.
REQ-026 pixel_x/pixel_y = col/line when de=1, else 0.
REQ-027 hsync active while RES_W+H_FP <= col < RES_W+H_FP+H_SYNC; vsync active while RES_H+V_FP <= line < RES_H+V_FP+V_SYNC, for full lines.
REQ-028 frame_start pulses for col=0,line=0; line_start pulses for col=0 of every line (both only when state≠IDLE).
REQ-029 en toggling within a frame SHALL never truncate a frame; en=1 during DRAIN continues seamlessly.

Reset
REQ-030 While rst=1: state IDLE, col=line=0, r_addr=0, r_en=0, pipeline cleared, de=0, colour=0, pixel_x/y=0, pulses=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
REQ-031 rst asserted mid-frame SHALL abort immediately; after release a new frame starts from col=0,line=0 if en=1.

Configuration
REQ-032 Macro VIDEO_TIMING_GEN_PATTERN_EN: when defined, input pat_sel (1 bit) is added; pat_sel=1 replaces r_data with 8 vertical colour bars (bar index = pixel_x*8/RES_W, colours white,yellow,cyan,green,magenta,red,blue,black, channels all-ones or 0) and forces r_en=0; timing unchanged.
REQ-033 Without the macro, pat_sel does not exist and colour always comes from r_data.

Verification (RES_W=8,RES_H=4,H_FP=2,H_SYNC=3,H_BP=1,V_FP=1,V_SYNC=1,V_BP=1,RD_LATENCY=2; H_TOT=14,V_TOT=7)
REQ-034 rst released, en=1 -> r_en high cycles 0..7 with r_addr 0..7; de high cycles 2..9; frame_start at cycle 2; hsync low for col 10..12 seen at cycles 12..14.
REQ-035 Model buffer returns data=addr with 2-cycle latency -> {red,green,blue}=pixel_y*8+pixel_x for all 32 active pixels; 0 in blanking.
REQ-036 Run 2 frames -> r_addr wraps 31->0, frame period 98 cycles, vsync low exactly 14 cycles per frame (line 5).
REQ-037 en dropped at line 2 col 3 -> frame completes to cycle 97, then IDLE with r_en=0, de=0; re-raise en -> frame_start 2 cycles later.
REQ-038 rst pulsed at line 3 col 5 -> all outputs at REQ-030 values in the same cycle; clean frame restart after release.
REQ-039 With VIDEO_TIMING_GEN_PATTERN_EN, pat_sel=1 -> pixel_x=0 white (all ones), pixel_x=7 black, r_en stays 0.
